uart_tx_sched: RTL

//  Transmit scheduler for the MiniUART. Shares the UART transmitter among N_REQ byte

---
 rtl/uart_tx_sched_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 28 ++
 rtl/uart_tx_sched.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the MiniUART transmit scheduler.
// Holds the FSM encoding, the LSR idle bit and the UART register offsets.
package uart_tx_sched_pkg;

  typedef enum logic [2:0] {
    StCfgDivr,
    StCfgDivt,
    StIdle,
    StPoll,
    StSend,
    StHold
  } state_e;

  localparam int unsigned LSR_TS_BIT = 5;

  // MiniUART register offsets, addressed on ADD_O[4:2]
  localparam logic [2:0] OFF_UART_DATA = 3'd0;
  localparam logic [2:0] OFF_UART_LSR  = 3'd1;
  localparam logic [2:0] OFF_UART_DIVR = 3'd2;
  localparam logic [2:0] OFF_UART_DIVT = 3'd3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after i_ptr in circular order.
// One-hot o_gnt, all zero when nothing requests.
module rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned PtrW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    i_req,
  input  logic [PtrW-1:0] i_ptr,
  output logic [N-1:0]    o_gnt
);

  logic            w_found;
  logic [PtrW-1:0] w_idx;

  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 1; k <= int'(N); k++) begin
      w_idx = PtrW'((int'(i_ptr) + k) % int'(N));
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin transmit scheduler acting as WISHBONE master on the MiniUART slave port.
// Define UART_SCHED_BAUDCFG_EN to write DIVR/DIVT once after reset before serving requests.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned HOLDOFF  = 4,
  parameter logic [15:0] DIVR_VAL = 16'd2604,
  parameter logic [15:0] DIVT_VAL = 16'd2604
) (
  input  logic               CLK_I,
  input  logic               RST_N_I,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic [4:2]         ADD_O,
  output logic [31:0]        DAT_O,
  input  logic [31:0]        DAT_I,
  output logic               STB_O,
  output logic               WE_O,
  input  logic               ACK_I,
  output logic               busy,
  output logic [15:0]        tx_count
);

  localparam int unsigned PtrW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CntW = $clog2(HOLDOFF);

`ifdef UART_SCHED_BAUDCFG_EN
  localparam state_e StReset = StCfgDivr;
`else
  localparam state_e StReset = StIdle;
`endif

  state_e          r_state, w_state_nxt;
  logic            r_run;
  logic [PtrW-1:0] r_rr_ptr, w_win;
  logic [7:0]      r_byte, w_byte;
  logic [CntW-1:0] r_cnt;
  logic [15:0]     r_tx_count;
  logic [N_REQ-1:0] w_gnt;
  logic            w_grant, w_send_done;
  logic            w_unused_dat;

  assign w_unused_dat = ^{DAT_I[31:LSR_TS_BIT+1], DAT_I[LSR_TS_BIT-1:0]};

  rr_arbiter #(
    .N    (N_REQ),
    .PtrW (PtrW)
  ) u_arb (
    .i_req (req_valid),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt)
  );

  always_comb begin
    w_win  = '0;
    w_byte = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (w_gnt[i]) begin
        w_win  = PtrW'(i);
        w_byte = req_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    STB_O       = 1'b0;
    WE_O        = 1'b0;
    ADD_O       = '0;
    DAT_O       = '0;
    req_ready   = '0;
    w_grant     = 1'b0;
    w_send_done = 1'b0;
    unique case (r_state)
      StCfgDivr: if (r_run) begin
        STB_O = 1'b1;
        WE_O  = 1'b1;
        ADD_O = OFF_UART_DIVR;
        DAT_O = {16'b0, DIVR_VAL};
        if (ACK_I) w_state_nxt = StCfgDivt;
      end
      StCfgDivt: begin
        STB_O = 1'b1;
        WE_O  = 1'b1;
        ADD_O = OFF_UART_DIVT;
        DAT_O = {16'b0, DIVT_VAL};
        if (ACK_I) w_state_nxt = StIdle;
      end
      StIdle: if (r_run && |req_valid) begin
        w_grant     = 1'b1;
        req_ready   = w_gnt;
        w_state_nxt = StPoll;
      end
      StPoll: begin
        STB_O = 1'b1;
        ADD_O = OFF_UART_LSR;
        if (ACK_I && DAT_I[LSR_TS_BIT]) w_state_nxt = StSend;
      end
      StSend: begin
        STB_O = 1'b1;
        WE_O  = 1'b1;
        ADD_O = OFF_UART_DATA;
        DAT_O = {24'b0, r_byte};
        if (ACK_I) begin
          w_send_done = 1'b1;
          w_state_nxt = StHold;
        end
      end
      StHold: if (r_cnt == '0) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // r_run keeps every output quiet during reset and the first cycle after release
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      r_state    <= StReset;
      r_run      <= 1'b0;
      r_rr_ptr   <= PtrW'(N_REQ - 1);
      r_byte     <= '0;
      r_cnt      <= '0;
      r_tx_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= 1'b1;
      if (w_grant) begin
        r_rr_ptr <= w_win;
        r_byte   <= w_byte;
      end
      if (w_send_done) begin
        r_tx_count <= r_tx_count + 16'd1;
        r_cnt      <= CntW'(HOLDOFF - 1);
      end else if (r_state == StHold && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign busy     = r_run && (r_state != StIdle);
  assign tx_count = r_tx_count;

endmodule
